// File: rtl/player_controller.sv
// player_controller: debounced four-button XY mover
// with step timing, speed boost and clamped loads.
module player_controller #(
  parameter int POS_W           = 10,
  parameter int INIT_X          = 320,
  parameter int INIT_Y          = 300,
  parameter int MIN_X           = 20,
  parameter int MAX_X           = 620,
  parameter int MIN_Y           = 62,
  parameter int MAX_Y           = 485,
  parameter int STEP_PERIOD     = 100,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FAST_AFTER      = 8,
  parameter int FAST_STEP       = 2,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [1:0]       dir_x,
  output logic [1:0]       dir_y,
  output logic             at_limit_x,
  output logic             at_limit_y
);

  localparam int EXT_W = POS_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W  = $clog2(STEP_PERIOD + 1);
  localparam int SC_W  = $clog2(FAST_AFTER + 2);
  localparam logic REL = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_POS  = 2'd2
  } axis_e;

  // Button index: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]      raw;
  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [3:0]      db_q;
  logic [3:0]      db_d;
  logic [DB_W-1:0] dcnt_q [4];
  logic [DB_W-1:0] dcnt_d [4];
  logic [3:0]      pressed;
  logic [1:0]      neg_b;
  logic [1:0]      pos_b;

  // Axis index: 0 x, 1 y.
  axis_e            st_q   [2];
  axis_e            st_d   [2];
  axis_e            want   [2];
  logic [TM_W-1:0]  tm_q   [2];
  logic [TM_W-1:0]  tm_d   [2];
  logic [SC_W-1:0]  sc_q   [2];
  logic [SC_W-1:0]  sc_d   [2];
  logic [POS_W-1:0] pos_q  [2];
  logic [POS_W-1:0] pos_d  [2];

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  function automatic logic [EXT_W-1:0] lo_of(input int a);
    return (a == 0) ? EXT_W'(MIN_X) : EXT_W'(MIN_Y);
  endfunction

  function automatic logic [EXT_W-1:0] hi_of(input int a);
    return (a == 0) ? EXT_W'(MAX_X) : EXT_W'(MAX_Y);
  endfunction

  function automatic logic [POS_W-1:0] clamp(
    input logic [POS_W-1:0] v,
    input int               a
  );
    logic [EXT_W-1:0] e;
    logic [EXT_W-1:0] r;
    e = {1'b0, v};
    r = e;
    if (e < lo_of(a)) r = lo_of(a);
    if (e > hi_of(a)) r = hi_of(a);
    return r[POS_W-1:0];
  endfunction

  // Wide arithmetic so the bound test sees the
  // true sum before it is narrowed back.
  function automatic logic [POS_W-1:0] step_pos(
    input logic [POS_W-1:0] p,
    input logic [EXT_W-1:0] amt,
    input logic             neg,
    input int               a
  );
    logic [EXT_W-1:0] e;
    logic [EXT_W-1:0] r;
    e = {1'b0, p};
    if (neg) begin
      r = (e < lo_of(a) + amt) ? lo_of(a) : e - amt;
    end else begin
      r = (e + amt > hi_of(a)) ? hi_of(a) : e + amt;
    end
    return r[POS_W-1:0];
  endfunction

  // Two-flop synchronizers, parked at the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {4{REL}};
      sync2_q <= {4{REL}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip only after a full run of disagreeing cycles.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]   = db_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounced level and run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= {4{REL}};
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign pressed = REL ? ~db_q : db_q;
  assign neg_b   = {pressed[0], pressed[2]};
  assign pos_b   = {pressed[1], pressed[3]};

  // Requested axis state from the debounced pair.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      want[a] = S_IDLE;
      unique case (1'b1)
        (neg_b[a] & ~pos_b[a]): want[a] = S_NEG;
        (pos_b[a] & ~neg_b[a]): want[a] = S_POS;
        default:                want[a] = S_IDLE;
      endcase
    end
  end

  // Axis FSM, step timer, boost count and position.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_d[a]  = st_q[a];
      tm_d[a]  = tm_q[a];
      sc_d[a]  = sc_q[a];
      pos_d[a] = pos_q[a];
      if (load_en) begin
        pos_d[a] = clamp((a == 0) ? load_x : load_y, a);
        tm_d[a]  = '0;
        sc_d[a]  = '0;
      end else if (want[a] != st_q[a]) begin
        st_d[a] = want[a];
        tm_d[a] = '0;
        sc_d[a] = '0;
      end else if (st_q[a] != S_IDLE) begin
        if (tm_q[a] == TM_W'(STEP_PERIOD - 1)) begin
          tm_d[a]  = '0;
          pos_d[a] = step_pos(
            pos_q[a],
            (sc_q[a] >= SC_W'(FAST_AFTER)) ?
              EXT_W'(FAST_STEP) : EXT_W'(1),
            (st_q[a] == S_NEG),
            a);
          if (sc_q[a] < SC_W'(FAST_AFTER)) begin
            sc_d[a] = sc_q[a] + SC_W'(1);
          end
        end else begin
          tm_d[a] = tm_q[a] + TM_W'(1);
        end
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        st_q[a] <= S_IDLE;
        tm_q[a] <= '0;
        sc_q[a] <= '0;
      end
      pos_q[0] <= POS_W'(INIT_X);
      pos_q[1] <= POS_W'(INIT_Y);
    end else begin
      for (int a = 0; a < 2; a++) begin
        st_q[a]  <= st_d[a];
        tm_q[a]  <= tm_d[a];
        sc_q[a]  <= sc_d[a];
        pos_q[a] <= pos_d[a];
      end
    end
  end

  assign pos_x = pos_q[0];
  assign pos_y = pos_q[1];
  assign dir_x = st_q[0];
  assign dir_y = st_q[1];

  assign at_limit_x = (pos_q[0] == POS_W'(MIN_X)) ||
                      (pos_q[0] == POS_W'(MAX_X));
  assign at_limit_y = (pos_q[1] == POS_W'(MIN_Y)) ||
                      (pos_q[1] == POS_W'(MAX_Y));

endmodule

// File: tb/tb_player_controller.sv
// tb_player_controller: scoreboarded random and
// directed stimulus against a behavioural model.
module tb_player_controller;

  localparam int STEP = 100;
  localparam int DEB  = 16;
  localparam int FA   = 8;
  localparam int FS   = 2;
  localparam int LO[2] = '{20, 62};
  localparam int HI[2] = '{620, 485};

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       load_en;
  logic [9:0] load_x, load_y;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir_x, dir_y;
  logic       at_limit_x, at_limit_y;

  always #5 clk = ~clk;

  player_controller dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .load_en(load_en), .load_x(load_x), .load_y(load_y),
    .pos_x(pos_x), .pos_y(pos_y),
    .dir_x(dir_x), .dir_y(dir_y),
    .at_limit_x(at_limit_x), .at_limit_y(at_limit_y)
  );

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] dx;
    logic [1:0] dy;
    logic       lx;
    logic       ly;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  bit   done   = 0;

  // Model: sync pipeline, stable-run debounce, and
  // per-axis "cycles since run start" with steps
  // landing on every STEP-th cycle of the run.
  int m_s1[4], m_s2[4], m_db[4], m_dc[4];
  int m_dir[2], m_run[2], m_steps[2], m_pos[2];

  task automatic check(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, got, exp);
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 1; m_s2[i] = 1; m_db[i] = 1; m_dc[i] = 0;
    end
    for (int a = 0; a < 2; a++) begin
      m_dir[a] = 0; m_run[a] = 0; m_steps[a] = 0;
    end
    m_pos[0] = 320;
    m_pos[1] = 300;
  endtask

  task automatic model_edge();
    int   raw[4];
    int   want[2];
    bit   pr[4];
    int   amt;
    int   ld;
    obs_t o;
    raw[0] = btn_up;   raw[1] = btn_down;
    raw[2] = btn_left; raw[3] = btn_right;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) pr[i] = (m_db[i] == 0);
      want[0] = (pr[2] && !pr[3]) ? 1 :
                (pr[3] && !pr[2]) ? 2 : 0;
      want[1] = (pr[0] && !pr[1]) ? 1 :
                (pr[1] && !pr[0]) ? 2 : 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_dc[i]++;
          if (m_dc[i] == DEB) begin
            m_db[i] = m_s2[i];
            m_dc[i] = 0;
          end
        end else m_dc[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      for (int a = 0; a < 2; a++) begin
        if (load_en) begin
          ld = (a == 0) ? int'(load_x) : int'(load_y);
          m_pos[a] = clampi(ld, LO[a], HI[a]);
          m_run[a] = 0; m_steps[a] = 0;
        end else if (want[a] != m_dir[a]) begin
          m_dir[a] = want[a];
          m_run[a] = 0; m_steps[a] = 0;
        end else if (m_dir[a] != 0) begin
          m_run[a]++;
          if (m_run[a] % STEP == 0) begin
            amt = (m_steps[a] >= FA) ? FS : 1;
            if (m_dir[a] == 1) amt = -amt;
            m_pos[a] = clampi(m_pos[a] + amt, LO[a], HI[a]);
            m_steps[a]++;
          end
        end
      end
    end
    o.px = 10'(m_pos[0]);
    o.py = 10'(m_pos[1]);
    o.dx = 2'(m_dir[0]);
    o.dy = 2'(m_dir[1]);
    o.lx = (m_pos[0] == LO[0]) || (m_pos[0] == HI[0]);
    o.ly = (m_pos[1] == LO[1]) || (m_pos[1] == HI[1]);
    exp_q.push_back(o);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Monitor: one scoreboard pop per active edge.
  initial begin
    obs_t e;
    obs_t g;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{pos_x, pos_y, dir_x, dir_y,
              at_limit_x, at_limit_y};
        n_chk++;
        if (g === e) n_pass++;
        else $display(
          "FAIL outputs @%0t: got x=%0d y=%0d dx=%0d dy=%0d lx=%0b ly=%0b expected x=%0d y=%0d dx=%0d dy=%0d lx=%0b ly=%0b",
          $time, g.px, g.py, g.dx, g.dy, g.lx, g.ly,
          e.px, e.py, e.dx, e.dy, e.lx, e.ly);
      end
    end
  end

  initial begin
    rst = 1'b1;
    btn_up = 1'b1; btn_down = 1'b1;
    btn_left = 1'b1; btn_right = 1'b1;
    load_en = 1'b0; load_x = '0; load_y = '0;
    model_reset();
    ticks(3);
    check("reset_pos_x", pos_x, 320);
    check("reset_pos_y", pos_y, 300);
    check("reset_lim_y", at_limit_y, 0);
    rst = 1'b0;

    btn_up = 1'b0;
    ticks(18);
    check("dir_y_before_debounce", dir_y, 0);
    ticks(1);
    check("dir_y_after_19", dir_y, 1);
    ticks(99);
    check("pos_y_before_step1", pos_y, 300);
    ticks(1);
    check("pos_y_step1", pos_y, 299);
    ticks(100);
    check("pos_y_step2", pos_y, 298);
    ticks(600);
    check("pos_y_step8", pos_y, 292);
    ticks(400);
    check("pos_y_step12", pos_y, 284);
    btn_up = 1'b1;
    ticks(30);
    check("dir_y_released", dir_y, 0);

    btn_up = 1'b0; btn_down = 1'b0;
    ticks(1019);
    check("both_dir_y", dir_y, 0);
    check("both_pos_y", pos_y, 284);
    btn_up = 1'b1; btn_down = 1'b1;
    ticks(30);

    load_en = 1'b1; load_x = 10'd320; load_y = 10'd64;
    ticks(1);
    load_en = 1'b0;
    check("load_pos_y", pos_y, 64);
    btn_up = 1'b0;
    ticks(119);
    check("low_step1", pos_y, 63);
    ticks(100);
    check("low_step2", pos_y, 62);
    check("low_lim_y", at_limit_y, 1);
    ticks(100);
    check("low_hold", pos_y, 62);
    btn_up = 1'b1;
    ticks(30);

    btn_left = 1'b0;
    ticks(10);
    btn_left = 1'b1;
    ticks(40);
    check("glitch_dir_x", dir_x, 0);
    check("glitch_pos_x", pos_x, 320);

    btn_right = 1'b0;
    ticks(19);
    check("right_dir_x", dir_x, 2);
    ticks(99);
    check("right_before_step", pos_x, 320);
    load_en = 1'b1; load_x = 10'd700; load_y = 10'd300;
    ticks(1);
    load_en = 1'b0;
    check("load_clamp_x", pos_x, 620);
    check("load_lim_x", at_limit_x, 1);
    ticks(50);
    load_en = 1'b1; load_x = 10'd500;
    ticks(1);
    load_en = 1'b0;
    ticks(99);
    check("timer_cleared_hold", pos_x, 500);
    ticks(1);
    check("timer_cleared_step", pos_x, 501);
    btn_right = 1'b1;
    ticks(30);

    btn_down = 1'b0;
    ticks(70);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pos_x", pos_x, 320);
    check("async_rst_pos_y", pos_y, 300);
    check("async_rst_dir_y", dir_y, 0);
    ticks(2);
    rst = 1'b0;
    ticks(5);
    btn_down = 1'b1;
    ticks(30);

    for (int s = 0; s < 40; s++) begin
      btn_up    = ($urandom_range(0, 2) != 0);
      btn_down  = ($urandom_range(0, 2) != 0);
      btn_left  = ($urandom_range(0, 2) != 0);
      btn_right = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) begin
        load_en = 1'b1;
        load_x  = 10'($urandom_range(0, 1023));
        load_y  = 10'($urandom_range(0, 1023));
        ticks(1);
        load_en = 1'b0;
      end
      ticks($urandom_range(5, 250));
    end

    ticks(2);
    done = 1'b1;
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
